// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage.
package core_pkg;

  // Reset PC used when the integrator does not override it.
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. The head is read straight out of
// the storage registers, so a pushed entry becomes visible on the next cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] cnt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A push into a full FIFO is only allowed when the head leaves the same cycle.
  assign pop_ok_s  = pop_i && (cnt_r != {CW{1'b0}});
  assign push_ok_s = push_i && ((cnt_r < CW'(DEPTH)) || pop_ok_s);

  // Storage, pointers and occupancy; clear empties the FIFO in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= entry_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head_o = mem_r[rd_ptr_r];
  assign cnt_o  = cnt_r;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for the fetch stage, kept apart from the datapath.
module fetch_unit_checker #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2,
  parameter int unsigned DW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          rvalid_i,
  input logic [CW-1:0] outst_i,
  input logic [DW-1:0] disc_i,
  input logic [CW-1:0] fifo_cnt_i,
  input logic          push_i,
  input logic          pop_i
);

  // A response is only legal while some request is still owed one.
  a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_i |-> ((outst_i != {CW{1'b0}}) || (disc_i != {DW{1'b0}})));

  // The credit rule must keep every push inside the FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_i && !pop_i) |-> (fifo_cnt_i < CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, tracks outstanding and
// wrong-path responses, and buffers instructions with their PCs for ID.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_if_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        valid_if_o,
  output logic [31:0] instr_if_o,
  output logic [31:0] pc_if_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // The discard counter gets one extra bit: back-to-back redirects against a
  // slow memory can leave more than DEPTH wrong-path responses pending.
  localparam int unsigned DW = CW + 1;
  localparam int unsigned TW = DW + 1;
  localparam logic [DW-1:0] DISC_MAX = {DW{1'b1}};

  logic [31:0]   fpc_r, fpc_n;
  logic [CW-1:0] outst_r, outst_n;
  logic [DW-1:0] disc_r, disc_n;
  logic          held_r, held_n;
  logic          held_stale_r, held_stale_n;
  logic [31:0]   held_addr_r, held_addr_n;

  logic [CW-1:0] fifo_cnt_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;
  logic [CW:0]   credit_sum_s;
  logic [TW-1:0] pend_total_s;
  logic          credit_ok_s;
  logic          room_ok_s;
  logic          req_s;
  logic [31:0]   addr_s;
  logic          gnt_s;
  logic          stale_gnt_s;
  logic          fresh_gnt_s;
  logic          rsp_drop_s;
  logic          rsp_live_s;
  logic          rsp_any_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_s;
  logic [31:0]   push_pc_s;

  // Issue credit counts buffered plus in-flight correct-path fetches; the room
  // check keeps the total pending response count representable.
  assign credit_sum_s = (CW + 1)'(outst_r) + (CW + 1)'(fifo_cnt_s);
  assign credit_ok_s  = credit_sum_s < (CW + 1)'(DEPTH);
  assign pend_total_s = TW'(disc_r) + TW'(outst_r);
  assign room_ok_s    = pend_total_s < TW'(DISC_MAX);

  // A held request stays up with its original address until granted.
  assign req_s  = !rst_i && (held_r || (!redirect_i && credit_ok_s && room_ok_s));
  assign addr_s = held_r ? held_addr_r : word_align(fpc_r);
  assign gnt_s  = req_s && imem_gnt_i;

  // Grants of requests raised before a redirect belong to the wrong path.
  assign stale_gnt_s = gnt_s && (redirect_i || (held_r && held_stale_r));
  assign fresh_gnt_s = gnt_s && !stale_gnt_s;

  // In-order responses: discarded ones always precede correct-path ones.
  assign rsp_drop_s = imem_rvalid_i && (disc_r != {DW{1'b0}});
  assign rsp_live_s = imem_rvalid_i && (disc_r == {DW{1'b0}}) && (outst_r != {CW{1'b0}});
  assign rsp_any_s  = rsp_drop_s || rsp_live_s;

  // The oldest correct-path request was issued outst_r words behind fpc_r.
  assign push_pc_s    = fpc_r - (32'(outst_r) << 2);
  assign push_entry_s = '{pc: push_pc_s, instr: imem_rdata_i};

  assign valid_s = (fifo_cnt_s != {CW{1'b0}}) && !redirect_i;
  assign pop_s   = valid_s && !stall_if_i;
  assign push_s  = rsp_live_s && !redirect_i;

  // Next fetch PC and counters; a redirect folds in-flight requests into discard.
  always_comb begin
    outst_n = outst_r;
    disc_n  = disc_r;
    fpc_n   = fpc_r;
    if (redirect_i) begin
      outst_n = {CW{1'b0}};
      disc_n  = disc_r + DW'(outst_r) + DW'(stale_gnt_s) - DW'(rsp_any_s);
      fpc_n   = word_align(redirect_addr_i);
    end else begin
      outst_n = outst_r + CW'(fresh_gnt_s) - CW'(rsp_live_s);
      disc_n  = disc_r + DW'(stale_gnt_s) - DW'(rsp_drop_s);
      if (fresh_gnt_s) begin
        fpc_n = fpc_r + 32'd4;
      end else begin
        fpc_n = fpc_r;
      end
    end
  end

  // Remember an ungranted request and whether a redirect has orphaned it.
  always_comb begin
    held_n       = 1'b0;
    held_stale_n = 1'b0;
    held_addr_n  = held_addr_r;
    if (req_s && !imem_gnt_i) begin
      held_n       = 1'b1;
      held_stale_n = (held_r && held_stale_r) || redirect_i;
      held_addr_n  = addr_s;
    end else begin
      held_n       = 1'b0;
      held_stale_n = 1'b0;
      held_addr_n  = held_addr_r;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fpc_r        <= word_align(BOOT_ADDR);
      outst_r      <= {CW{1'b0}};
      disc_r       <= {DW{1'b0}};
      held_r       <= 1'b0;
      held_stale_r <= 1'b0;
      held_addr_r  <= word_align(BOOT_ADDR);
    end else begin
      fpc_r        <= fpc_n;
      outst_r      <= outst_n;
      disc_r       <= disc_n;
      held_r       <= held_n;
      held_stale_r <= held_stale_n;
      held_addr_r  <= held_addr_n;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (push_s),
    .entry_i (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .cnt_o   (fifo_cnt_s)
  );

  fetch_unit_checker #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .DW    (DW)
  ) u_checker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rvalid_i   (imem_rvalid_i),
    .outst_i    (outst_r),
    .disc_i     (disc_r),
    .fifo_cnt_i (fifo_cnt_s),
    .push_i     (push_s),
    .pop_i      (pop_s)
  );

  assign imem_req_o  = req_s;
  assign imem_addr_o = addr_s;
  assign valid_if_o  = valid_s;
  assign instr_if_o  = head_s.instr;
  assign pc_if_o     = head_s.pc;

endmodule
